// File: rtl/digit_serial_adder.sv
// Digit-serial adder: adds WIDTH-bit operands plus carry-in DIGIT bits per clock,
// LSB digit first, through a single reused DIGIT-bit adder slice.
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             Cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NDIG - 1);

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("digit_serial_adder: DIGIT must be >= 1 and divide WIDTH exactly");
    end
  endgenerate

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] psum_r;
  logic [WIDTH-1:0] s_r;
  logic [KW-1:0]    k_r;
  logic             carry_r;
  logic             busy_r;
  logic             done_r;
  logic             cout_r;
  logic             ovf_r;

  logic [IW-1:0]    base_s;
  logic [DIGIT-1:0] a_dig_s;
  logic [DIGIT-1:0] b_dig_s;
  logic [DIGIT:0]   slice_s;
  logic             msb_cin_s;
  logic [WIDTH-1:0] psum_next_s;

  // Shared adder slice on digit k, and the partial sum with that digit merged in
  always_comb begin
    base_s      = IW'(32'(k_r) * 32'(DIGIT));
    a_dig_s     = a_r[base_s +: DIGIT];
    b_dig_s     = b_r[base_s +: DIGIT];
    slice_s     = {1'b0, a_dig_s} + {1'b0, b_dig_s} + {{DIGIT{1'b0}}, carry_r};
    // Carry into the slice MSB; only meaningful on the last digit, where it feeds ovf
    msb_cin_s   = slice_s[DIGIT-1] ^ a_dig_s[DIGIT-1] ^ b_dig_s[DIGIT-1];
    psum_next_s = psum_r;
    psum_next_s[base_s +: DIGIT] = slice_s[DIGIT-1:0];
  end

  // Control FSM, operand capture, digit sequencing and registered results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      psum_r  <= {WIDTH{1'b0}};
      s_r     <= {WIDTH{1'b0}};
      k_r     <= {KW{1'b0}};
      carry_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            carry_r <= cin;
            psum_r  <= {WIDTH{1'b0}};
            k_r     <= {KW{1'b0}};
            busy_r  <= 1'b1;
            state_r <= RUN;
          end
        end
        RUN: begin
          psum_r  <= psum_next_s;
          carry_r <= slice_s[DIGIT];
          if (k_r == K_LAST) begin
            s_r    <= psum_next_s;
            cout_r <= slice_s[DIGIT];
            ovf_r  <= msb_cin_s ^ slice_s[DIGIT];
            done_r <= 1'b1;
            // A pending start chains straight into the next operation
            if (start) begin
              a_r     <= a;
              b_r     <= b;
              carry_r <= cin;
              psum_r  <= {WIDTH{1'b0}};
              k_r     <= {KW{1'b0}};
              busy_r  <= 1'b1;
              state_r <= RUN;
            end else begin
              busy_r  <= 1'b0;
              state_r <= IDLE;
            end
          end else begin
            k_r <= k_r + {{(KW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign s    = s_r;
  assign Cout = cout_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed and random checks of digit_serial_adder at DIGIT=4, 1 and 16 (WIDTH=16).
module tb_digit_serial_adder;

  logic        clk;
  logic        rst;
  logic        start4;
  logic        startx;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;

  logic        busy4, done4, cout4, ovf4;
  logic [15:0] s4;
  logic        busy1, done1, cout1, ovf1;
  logic [15:0] s1;
  logic        busy16, done16, cout16, ovf16;
  logic [15:0] s16;

  int vectors;
  int miscompares;

  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a), .b(b), .cin(cin),
    .busy(busy4), .done(done4), .s(s4), .Cout(cout4), .ovf(ovf4)
  );

  digit_serial_adder #(.WIDTH(16), .DIGIT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(startx), .a(a), .b(b), .cin(cin),
    .busy(busy1), .done(done1), .s(s1), .Cout(cout1), .ovf(ovf1)
  );

  digit_serial_adder #(.WIDTH(16), .DIGIT(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(startx), .a(a), .b(b), .cin(cin),
    .busy(busy16), .done(done16), .s(s16), .Cout(cout16), .ovf(ovf16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until u_dut4 pulses done; n is the number of edges taken (12 if it never did)
  task automatic wait4(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done4 && n < 12);
  endtask

  task automatic run4(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                      input logic tc, input logic [15:0] es, input logic ec, input logic eo);
    logic [15:0] prev;
    int n;
    prev   = s4;
    a      = ta;
    b      = tb_;
    cin    = tc;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    check({tag, "_busy"}, busy4, 1'b1);
    check({tag, "_hold"}, s4, prev);
    wait4(n);
    check({tag, "_lat"}, n, 32'd4);
    check({tag, "_s"}, s4, es);
    check({tag, "_cout"}, cout4, ec);
    check({tag, "_ovf"}, ovf4, eo);
    check({tag, "_busy_done"}, busy4, 1'b0);
    tick();
    check({tag, "_done_pulse"}, done4, 1'b0);
  endtask

  initial begin
    int n;
    int lat1;
    int lat16;
    logic seen;
    logic [16:0] esum;
    logic eovf;

    vectors     = 0;
    miscompares = 0;
    rst    = 1'b1;
    start4 = 1'b0;
    startx = 1'b0;
    a      = 16'h0000;
    b      = 16'h0000;
    cin    = 1'b0;
    tick();
    tick();
    check("rst_busy", busy4, 1'b0);
    check("rst_done", done4, 1'b0);
    check("rst_s", s4, 16'h0000);
    check("rst_cout", cout4, 1'b0);
    check("rst_ovf", ovf4, 1'b0);
    rst = 1'b0;
    tick();

    run4("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    run4("wrap", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    run4("posovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run4("negovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    // start re-asserted during RUN cycles 1 and 2 with new operands must be ignored
    a = 16'h0102; b = 16'h0304; cin = 1'b0; start4 = 1'b1;
    tick();
    a = 16'hAAAA; b = 16'h5555; cin = 1'b1;
    tick();
    tick();
    start4 = 1'b0;
    check("ign_hold", s4, 16'h0000);
    check("ign_busy", busy4, 1'b1);
    wait4(n);
    check("ign_lat", n, 32'd2);
    check("ign_s", s4, 16'h0406);
    check("ign_cout", cout4, 1'b0);
    check("ign_ovf", ovf4, 1'b0);
    tick();
    check("ign_idle", busy4, 1'b0);

    // start held high: three chained operations, one result every 4 edges
    a = 16'h1111; b = 16'h2222; cin = 1'b0; start4 = 1'b1;
    tick();
    a = 16'hF000; b = 16'h1000; cin = 1'b1;
    wait4(n);
    check("chain1_lat", n, 32'd4);
    check("chain1_s", s4, 16'h3333);
    check("chain1_cout", cout4, 1'b0);
    check("chain1_busy", busy4, 1'b1);
    a = 16'h4000; b = 16'h4000; cin = 1'b0;
    wait4(n);
    check("chain2_lat", n, 32'd4);
    check("chain2_s", s4, 16'h0001);
    check("chain2_cout", cout4, 1'b1);
    check("chain2_ovf", ovf4, 1'b0);
    start4 = 1'b0;
    wait4(n);
    check("chain3_lat", n, 32'd4);
    check("chain3_s", s4, 16'h8000);
    check("chain3_cout", cout4, 1'b0);
    check("chain3_ovf", ovf4, 1'b1);
    check("chain3_busy", busy4, 1'b0);

    // asynchronous reset in the middle of RUN aborts the operation
    a = 16'h00FF; b = 16'h0001; cin = 1'b0; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    check("abort_s", s4, 16'h0000);
    check("abort_ovf", ovf4, 1'b0);
    check("abort_busy", busy4, 1'b0);
    tick();
    tick();
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done4) seen = 1'b1;
    end
    check("abort_no_done", seen, 1'b0);
    run4("post_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    // bit-serial and single-cycle instances against a reference sum
    for (int v = 0; v < 1000; v++) begin
      a    = 16'($urandom);
      b    = 16'($urandom);
      cin  = 1'($urandom);
      esum = {1'b0, a} + {1'b0, b} + {16'h0000, cin};
      eovf = (a[15] == b[15]) && (esum[15] != a[15]);
      startx = 1'b1;
      tick();
      startx = 1'b0;
      lat1  = 0;
      lat16 = 0;
      n     = 0;
      while (n < 24 && (lat1 == 0 || lat16 == 0)) begin
        tick();
        n++;
        if (done1 && lat1 == 0) lat1 = n;
        if (done16 && lat16 == 0) lat16 = n;
      end
      check("d1_lat", lat1, 32'd16);
      check("d16_lat", lat16, 32'd1);
      check("d1_s", s1, esum[15:0]);
      check("d16_s", s16, esum[15:0]);
      check("d1_cout", cout1, esum[16]);
      check("d16_cout", cout16, esum[16]);
      check("d1_ovf", ovf1, eovf);
      check("d16_ovf", ovf16, eovf);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
